uart_receiver_n: RTL

UART_RECEIVER_N -- requirements
Module: uart_receiver_n

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_receiver_n.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, parity
// modes and an elaboration-time check of the parameter set.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RECOVER
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic bit uart_params_ok(input int data_bits, input int oversample,
                                        input int parity, input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && (oversample <= 64) && (oversample % 2 == 0) &&
           (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous rx line; 2 clk latency, no
// backpressure. Resets to 1 so an idle line never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver_n.sv
// Oversampling UART receiver with 3-sample majority voting and a one-word holding
// register; word appears 1 clk after the last stop sample, overrun if the register is still full.
module uart_receiver_n
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity_err,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_POST = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  if (!uart_params_ok(DATA_BITS, OVERSAMPLE, PARITY, STOP_BITS)) begin : g_param_check
    $error("uart_receiver_n: illegal parameter set");
  end

  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [1:0]           smp;
  logic                 hi_seen;
  logic                 armed;
  logic [DATA_BITS-1:0] data_r;
  logic                 par_err_r;

  logic          rx_s;
  logic          wrap;
  logic [CW-1:0] cnt_nxt;
  logic          at_post;
  logic          maj;
  logic          data_par;
  logic          par_bad;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (rx_s)
  );

  // cnt_nxt is the position within the current bit of the tick being processed
  assign wrap     = (cnt == C_LAST);
  assign cnt_nxt  = wrap ? '0 : cnt + 1'b1;
  assign at_post  = (cnt_nxt == C_POST);
  assign maj      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign data_par = ^data_r;
  assign par_bad  = (PARITY == PAR_ODD) ? ~(data_par ^ maj) : (data_par ^ maj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      smp            <= '0;
      hi_seen        <= 1'b0;
      armed          <= 1'b0;
      data_r         <= '0;
      par_err_r      <= 1'b0;
      out            <= '0;
      out_valid      <= 1'b0;
      out_parity_err <= 1'b0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!en) begin
        // armed drops so a line that is mid-frame when re-enabled is not taken as a start
        state   <= ST_IDLE;
        busy    <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
        smp     <= '0;
        hi_seen <= 1'b0;
        armed   <= 1'b0;
      end else if (tick) begin
        if (cnt_nxt == C_PRE) smp[0] <= rx_s;
        if (cnt_nxt == C_MID) smp[1] <= rx_s;
        cnt <= cnt_nxt;

        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= ST_START;
              busy  <= 1'b1;
            end
          end

          ST_START: begin
            if (cnt_nxt == C_MID) begin
              if (rx_s) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                armed <= 1'b1;
              end else begin
                // start-bit centre becomes the timing reference for all later bits
                cnt <= C_MID;
              end
            end else if (wrap) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end

          ST_DATA: begin
            if (at_post) data_r[bit_idx] <= maj;
            if (wrap) begin
              if (bit_idx == B_LAST_DATA) begin
                bit_idx <= '0;
                state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end

          ST_PARITY: begin
            if (at_post) par_err_r <= par_bad;
            if (wrap) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end
          end

          ST_STOP: begin
            if (at_post) begin
              if (!maj) begin
                frame_err <= 1'b1;
                hi_seen   <= 1'b0;
                state     <= ST_RECOVER;
              end else if (bit_idx == B_LAST_STOP) begin
                // back to IDLE mid stop bit so an early next start edge is caught
                state <= ST_IDLE;
                busy  <= 1'b0;
                armed <= 1'b1;
                cnt   <= '0;
                if (!out_valid || out_ready) begin
                  out            <= data_r;
                  out_parity_err <= (PARITY != PAR_NONE) && par_err_r;
                  out_valid      <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else if (wrap) begin
              bit_idx <= bit_idx + 1'b1;
            end
          end

          ST_RECOVER: begin
            cnt <= '0;
            if (rx_s) begin
              hi_seen <= 1'b1;
              if (hi_seen) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                armed <= 1'b1;
              end
            end else begin
              hi_seen <= 1'b0;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
